riscv_md_seq: RTL and testbench
===============================

RISCV_MD_SEQ -- requirements
Module: riscv_md_seq

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL provide port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port i_valid  input  1  EX stage presents an RV32M operation.
REQ-005 SHALL provide port o_ready  output  1  sequencer can accept an operation this cycle.
REQ-006 SHALL provide port i_funct3  input  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL provide port i_num1  input  32  rs1 operand.
REQ-008 SHALL provide port i_num2  input  32  rs2 operand.
REQ-009 SHALL provide port i_kill  input  1  pipeline flush; abandon the current operation.
REQ-010 SHALL provide port o_busy  output  1  operation in flight; EX stage stalls.
REQ-011 SHALL provide port o_valid  output  1  one-cycle pulse; o_num is the result.
REQ-012 SHALL provide port o_num  output  32  result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL drive o_ready=1 only in IDLE; acceptance = i_valid & o_ready & !i_kill.
REQ-015 SHALL latch funct3 and operands on acceptance; later changes to the inputs SHALL NOT affect the result.
REQ-016 SHALL move IDLE->CALC on a normal acceptance, with a 6-bit step counter loaded to 0.
REQ-017 SHALL perform one iteration per CALC cycle (shift-add multiply, restoring divide) on operand magnitudes and leave CALC after 32 iterations.
REQ-018 SHALL sign-correct results: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
REQ-019 SHALL return the low 32 product bits for MUL and the high 32 bits for MULH/MULHSU/MULHU.
REQ-020 SHALL sign the DIV quotient as rs1 xor rs2 and the REM remainder as rs1.
REQ-021 SHALL handle a divisor of 0 by fast path IDLE->DONE: quotient 0xFFFFFFFF, remainder = rs1.
REQ-022 SHALL handle signed overflow (0x80000000 / 0xFFFFFFFF) by fast path: DIV -> 0x80000000, REM -> 0.
REQ-023 SHALL give normal ops o_valid exactly 33 cycles after the acceptance edge and fast-path ops 1 cycle after.
REQ-024 SHALL drive o_valid = (state==DONE) & !i_kill, and DONE SHALL always go to IDLE next cycle.
REQ-025 SHALL drive o_busy = 1 in CALC and in DONE, and 0 in IDLE.
REQ-026 SHALL handle i_kill in CALC or DONE by going to IDLE next cycle, suppressing o_valid and leaving o_num unchanged.
REQ-027 SHALL update o_num only on the DONE entry edge and hold it otherwise.

Reset
REQ-028 SHALL, while i_rst=1, force state IDLE, counter 0, o_num 0, o_valid 0, o_busy 0, o_ready 0.
REQ-029 SHALL, on reset during CALC/DONE, discard the operation with no o_valid; o_ready=1 on the first cycle after i_rst deasserts.

Configuration
REQ-030 SHALL compile in the divider only when RISCV_DIV_EN is defined.
REQ-031 SHALL, with RISCV_DIV_EN defined, execute all eight M-ops per REQ-016..REQ-022.
REQ-032 SHALL, without RISCV_DIV_EN, contain no divide logic and take funct3[2]=1 ops on the fast path with o_num=0.

Structure
REQ-033 SHALL place these in shared package riscv_pkg: M-op funct3 codes, OP_MULDIV funct7 constant 7'b0000001, FSM state enum.
REQ-034 SHALL split the design into the FSM/handshake (top) and one sub-module riscv_md_datapath (operand registers, accumulator, counter-driven shift/add/sub).

Verification
REQ-035 SHALL verify MUL 7 x 6: o_valid at +33 with o_num=0x0000002A; o_busy=1 for cycles +1..+33.
REQ-036 SHALL verify MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU with the same operands -> 0xFFFFFFFE.
REQ-037 SHALL verify DIVU 100 / 0 -> 0xFFFFFFFF at +1; REM 0x80000000 % 0xFFFFFFFF -> 0x00000000 at +1.
REQ-038 SHALL verify DIV 0xFFFFFF9C (-100) / 7 -> 0xFFFFFFF2 (-14) and REM -> 0xFFFFFFFE (-2).
REQ-039 SHALL verify i_kill at +10 of a DIVU: no o_valid, o_ready=1 at +11, o_num keeps its prior value.
REQ-040 SHALL verify i_rst at +5 of a MUL, then a new MUL 3 x 3: only one o_valid, with 0x00000009, 33 cycles after the new acceptance.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-op funct3 codes, the MULDIV funct7 value and
// the multiply/divide sequencer state encoding.
// No ports (package).
package riscv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OP_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/riscv_md_datapath.sv
// Iterative RV32M datapath: operand magnitude registers, 64-bit accumulator
// (hi/lo), step counter, one shift-add (multiply) or restoring-subtract
// (divide) iteration per step, plus the single-cycle fast-path results.
// Ports: clk/rst (sync, active-high); start loads operands and clears the
//   counter; step runs one iteration; last flags the final iteration;
//   fast/fast_num give the fast-path decision and value from the live inputs;
//   res_num is the sign-corrected result of the iteration in progress.
// Divider logic exists only when RISCV_DIV_EN is defined.
module riscv_md_datapath
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] num1,
  input  logic [XLEN-1:0] num2,
  output logic            last,
  output logic            fast,
  output logic [XLEN-1:0] fast_num,
  output logic [XLEN-1:0] res_num
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      mop_q;
  logic            neg_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [5:0]      cnt_q;

  logic            a_sgn, b_sgn, sa, sb, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [XLEN:0]     msum;
  logic [XLEN-1:0]   mhi_n, mlo_n, mres;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   hi_n, lo_n;

  // Operand signedness and result sign, resolved from the inputs at start.
  // A remainder takes the dividend's sign; everything else is sa ^ sb.
  always_comb begin
    a_sgn  = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn  = funct3[2] ? ~funct3[0] : ~funct3[1];
    sa     = a_sgn & num1[XLEN-1];
    sb     = b_sgn & num2[XLEN-1];
    neg_in = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
    a_mag  = sa ? -num1 : num1;
    b_mag  = sb ? -num2 : num2;
  end

  // Shift-add multiply: lo holds the remaining multiplier bits and fills
  // with the low product bits from the top as it shifts right.
  always_comb begin
    msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mhi_n  = msum[XLEN:1];
    mlo_n  = {msum[0], lo_q[XLEN-1:1]};
    prod   = {mhi_n, mlo_n};
    prod_s = neg_q ? -prod : prod;
    mres   = (mop_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

`ifdef RISCV_DIV_EN
  logic            div_q;
  logic [XLEN:0]   dsh;
  logic [XLEN-1:0] dsub, dhi_n, dlo_n, dval, dres;
  logic            dge, dz, ovf;

  // Restoring divide: hi is the partial remainder, lo shifts the dividend
  // out at the top and the quotient bits in at the bottom. When the
  // subtraction succeeds the difference is below the divisor, so the low
  // XLEN bits of the modular subtract are exact.
  always_comb begin
    dsh   = {hi_q, lo_q[XLEN-1]};
    dge   = (dsh >= {1'b0, b_q});
    dsub  = dsh[XLEN-1:0] - b_q;
    dhi_n = dge ? dsub : dsh[XLEN-1:0];
    dlo_n = {lo_q[XLEN-2:0], dge};
    dval  = mop_q[1] ? dhi_n : dlo_n;
    dres  = neg_q ? -dval : dval;
    hi_n    = div_q ? dhi_n : mhi_n;
    lo_n    = div_q ? dlo_n : mlo_n;
    res_num = div_q ? dres : mres;
  end

  // Divide-by-zero and signed overflow never enter the iteration loop.
  always_comb begin
    dz   = funct3[2] & (num2 == '0);
    ovf  = funct3[2] & ~funct3[0] & (num1 == MIN_NEG) & (num2 == '1);
    fast = dz | ovf;
    if (dz) fast_num = funct3[1] ? num1 : '1;
    else    fast_num = funct3[1] ? '0 : MIN_NEG;
  end

  always_ff @(posedge clk) begin
    if (rst)        div_q <= 1'b0;
    else if (start) div_q <= funct3[2];
  end
`else
  always_comb begin
    hi_n    = mhi_n;
    lo_n    = mlo_n;
    res_num = mres;
    // Divide ops complete immediately with a zero result in this build.
    fast     = funct3[2];
    fast_num = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mop_q <= '0;
      neg_q <= 1'b0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else if (start) begin
      mop_q <= funct3[1:0];
      neg_q <= neg_in;
      b_q   <= b_mag;
      hi_q  <= '0;
      lo_q  <= a_mag;
      cnt_q <= '0;
    end else if (step) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign last = (cnt_q == 6'(XLEN-1));

endmodule

// File: rtl/riscv_md_seq.sv
// RV32M multiply/divide sequencer: IDLE/CALC/DONE handshake with the EX
// stage around an iterative datapath (32 iterations, result 33 cycles after
// acceptance; divide-by-zero, signed overflow take a 1-cycle fast path).
// Ports: i_clk, i_rst (sync, active-high); i_valid/o_ready accept an op
//   (i_funct3, i_num1, i_num2); i_kill abandons it; o_busy stalls EX while
//   in flight; o_valid pulses one cycle with the result on o_num.
// Build option: define RISCV_DIV_EN to include the divider.
module riscv_md_seq
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_num1,
  input  logic [XLEN-1:0] i_num2,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_num
);

  md_state_t       state, state_n;
  logic            accept, start, step, load;
  logic            last, fast;
  logic [XLEN-1:0] fast_num, res_num, num_n;

  riscv_md_datapath #(.XLEN(XLEN)) u_datapath (
    .clk      (i_clk),
    .rst      (i_rst),
    .start    (start),
    .step     (step),
    .funct3   (i_funct3),
    .num1     (i_num1),
    .num2     (i_num2),
    .last     (last),
    .fast     (fast),
    .fast_num (fast_num),
    .res_num  (res_num)
  );

  // Outputs are also gated by i_rst so they read inactive during the very
  // first reset cycle, before the state register has been cleared.
  always_comb begin
    o_ready = (state == IDLE) & ~i_rst;
    o_busy  = (state != IDLE) & ~i_rst;
    o_valid = (state == DONE) & ~i_kill & ~i_rst;
    accept  = i_valid & o_ready & ~i_kill;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    step    = 1'b0;
    load    = 1'b0;
    num_n   = res_num;
    case (state)
      IDLE: begin
        if (accept) begin
          start = 1'b1;
          if (fast) begin
            state_n = DONE;
            load    = 1'b1;
            num_n   = fast_num;
          end else begin
            state_n = CALC;
          end
        end
      end
      CALC: begin
        if (i_kill) begin
          state_n = IDLE;
        end else begin
          step = 1'b1;
          // The result is captured from the final iteration's combinational
          // output on the same edge that enters DONE.
          if (last) begin
            state_n = DONE;
            load    = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_num <= '0;
    end else begin
      state <= state_n;
      if (load) o_num <= num_n;
    end
  end

endmodule

// File: tb/tb_riscv_md_seq.sv
module tb_riscv_md_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_kill = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_num1 = '0;
  logic [31:0] i_num2 = '0;
  logic        o_ready, o_busy, o_valid;
  logic [31:0] o_num;

  always #5 clk = ~clk;

  riscv_md_seq #(.XLEN(32)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_funct3 (i_funct3),
    .i_num1   (i_num1),
    .i_num2   (i_num2),
    .i_kill   (i_kill),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_num    (o_num)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  int          due_q[$];
  string       tag_q[$];
  logic [31:0] last_exp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference RV32M semantics.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] as_, bs_;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    as_ = a;
    bs_ = b;
    r = '0;
    case (f3)
      3'b000: begin p = sa * sb; r = p[31:0];  end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
`ifdef RISCV_DIV_EN
      3'b100: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else r = as_ / bs_;
      end
      3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = '0;
        else r = as_ % bs_;
      end
      3'b111: r = (b == 0) ? a : a % b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) begin
`ifdef RISCV_DIV_EN
      if (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
`else
      return 1;
`endif
    end
    return 33;
  endfunction

  // Scoreboard consumer: every o_valid must match the oldest expected entry,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (!rst && o_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_valid", {31'b0, o_valid}, 32'd0);
      else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic int d = due_q.pop_front();
        automatic string t = tag_q.pop_front();
        check({t, "_result"}, o_num, e);
        check({t, "_latency"}, cyc, d);
      end
    end
  end

  // Waits for o_ready, presents one op for exactly the acceptance edge, then
  // scrambles the inputs. Returns #1 after the acceptance edge.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit track);
    int w;
    w = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (o_ready !== 1'b1) begin
      check({tag, "_ready_timeout"}, {31'b0, o_ready}, 32'd1);
      return;
    end
    if (track) begin
      last_exp = model(f3, a, b);
      exp_q.push_back(last_exp);
      due_q.push_back(cyc + latency(f3, a, b));
      tag_q.push_back(tag);
    end
    i_valid  = 1'b1;
    i_funct3 = f3;
    i_num1   = a;
    i_num2   = b;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_funct3 = 3'($urandom);
    i_num1   = $urandom;
    i_num2   = $urandom;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_drain_timeout"}, exp_q.size(), 32'd0);
      exp_q.delete();
      due_q.delete();
      tag_q.delete();
    end
  endtask

  initial begin
    int bad;
    logic [2:0]  f3;
    logic [31:0] a, b, prior;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, o_ready}, 32'd0);
    check("rst_busy",  {31'b0, o_busy},  32'd0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_num",   o_num,            32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'b0, o_ready}, 32'd1);

    // MUL 7 x 6 with busy window +1..+33 and idle at +34
    issue("mul7x6", 3'b000, 32'd7, 32'd6, 1'b1);
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (o_busy !== 1'b1) bad++;
    end
    check("mul_busy_window", bad, 32'd0);
    @(negedge clk);
    check("mul_busy_after", {31'b0, o_busy},  32'd0);
    check("mul_ready_after", {31'b0, o_ready}, 32'd1);
    drain("mul7x6");
    repeat (3) @(negedge clk);
    check("mul_num_hold", o_num, last_exp);

    // Multiply variants
    issue("mulh_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); drain("mulh_m1");
    issue("mulhu_m1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); drain("mulhu_m1");
    issue("mulhsu",    3'b010, 32'hFFFFFFFE, 32'd3,        1'b1); drain("mulhsu");
    issue("mul_min",   3'b000, 32'h80000000, 32'hFFFFFFFF, 1'b1); drain("mul_min");

    // Divide paths (all take the fast path with zero when the divider is absent)
    issue("divu_z",    3'b101, 32'd100,      32'd0,        1'b1); drain("divu_z");
    issue("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b1); drain("rem_ovf");
    issue("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b1); drain("div_ovf");
    issue("div_neg",   3'b100, 32'hFFFFFF9C, 32'd7,        1'b1); drain("div_neg");
    issue("rem_neg",   3'b110, 32'hFFFFFF9C, 32'd7,        1'b1); drain("rem_neg");
    issue("remu_z",    3'b111, 32'd100,      32'd0,        1'b1); drain("remu_z");
    issue("divu_1000", 3'b101, 32'd1000,     32'd7,        1'b1); drain("divu_1000");
    issue("rem_7_m3",  3'b110, 32'd7,        32'hFFFFFFFD, 1'b1); drain("rem_7_m3");

    // Random ops
    for (int i = 0; i < 8; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = (i % 3 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      b  = (i == 5) ? 32'd0 : $urandom;
      issue("rand", f3, a, b, 1'b1);
      drain("rand");
    end

    // Kill at +10 of a long op
    prior = last_exp;
`ifdef RISCV_DIV_EN
    issue("kill_op", 3'b101, 32'd12345, 32'd17, 1'b0);
`else
    issue("kill_op", 3'b011, 32'd12345, 32'd17, 1'b0);
`endif
    repeat (10) @(negedge clk);
    check("kill_busy_before", {31'b0, o_busy}, 32'd1);
    i_kill = 1'b1;
    @(posedge clk);
    #1;
    i_kill = 1'b0;
    @(negedge clk);
    check("kill_ready",  {31'b0, o_ready}, 32'd1);
    check("kill_busy",   {31'b0, o_busy},  32'd0);
    check("kill_valid",  {31'b0, o_valid}, 32'd0);
    check("kill_num",    o_num,            prior);
    repeat (40) @(negedge clk);

    // Reset at +5 of a MUL, then MUL 3 x 3
    issue("rst_op", 3'b000, 32'd5, 32'd5, 1'b0);
    repeat (5) @(negedge clk);
    check("rstop_busy_before", {31'b0, o_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstop_ready", {31'b0, o_ready}, 32'd0);
    check("rstop_busy",  {31'b0, o_busy},  32'd0);
    check("rstop_valid", {31'b0, o_valid}, 32'd0);
    check("rstop_num",   o_num,            32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstop_ready_after", {31'b0, o_ready}, 32'd1);
    issue("mul3x3", 3'b000, 32'd3, 32'd3, 1'b1);
    drain("mul3x3");
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
